// File: rtl/stack_pkg.sv
// Shared opcodes, FSM state encoding and fault codes for the data-stack engine.
// Imported by the stack unit and by the control FSM that issues commands to it.
package stack_pkg;

    localparam logic [2:0] STK_NOP   = 3'd0;
    localparam logic [2:0] STK_PUSH  = 3'd1;
    localparam logic [2:0] STK_POP   = 3'd2;
    localparam logic [2:0] STK_POP2  = 3'd3;
    localparam logic [2:0] STK_DUP   = 3'd4;
    localparam logic [2:0] STK_SWAP  = 3'd5;
    localparam logic [2:0] STK_PEEK  = 3'd6;
    localparam logic [2:0] STK_CLEAR = 3'd7;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_RESP = 3'd5
    } state_t;

    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OVF  = 2'd1;
    localparam logic [1:0] FLT_UNF  = 2'd2;

    // Overflow wins over underflow; the two cannot both apply to one command.
    function automatic logic [1:0] fault_code(input logic [2:0] op,
                                              input logic       is_full,
                                              input logic       is_empty,
                                              input logic       below_two);
        logic [1:0] code;
        code = FLT_NONE;
        if ((op == STK_PUSH || op == STK_DUP) && is_full)
            code = FLT_OVF;
        else if ((op == STK_DUP || op == STK_POP || op == STK_PEEK) && is_empty)
            code = FLT_UNF;
        else if ((op == STK_POP2 || op == STK_SWAP) && below_two)
            code = FLT_UNF;
        return code;
    endfunction

endpackage

// File: rtl/stack_ram.sv
// Single-port DEPTH x DATA_W stack storage, synchronous read (1 cycle), read-first.
// Contents are not reset.
module stack_ram #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/data_stack_unit.sv
// Operand-stack engine: one command at a time, rsp 1..4 cycles after acceptance.
// cmd_ready is high only in IDLE; no backpressure on the single-cycle response.
module data_stack_unit
    import stack_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_a,
    output logic [DATA_W-1:0] rsp_b,
    output logic              rsp_fault,
    output logic [PTR_W-1:0]  tos_ptr,
    output logic              full,
    output logic              empty,
    output logic              err_ovf,
    output logic              err_unf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_FULL = PTR_W'(DEPTH);

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_cur;
    logic [DATA_W-1:0] temp_a, temp_b;
    logic [DATA_W-1:0] ram_rdata, ram_wdata;
    logic [AW-1:0]     ram_addr, addr_free, addr_top, addr_second;
    logic              ram_we, accept, enter_resp, flt_now;
    logic [1:0]        flt;

    // Addresses wrap modulo the array size, so tos_ptr==DEPTH still maps top to DEPTH-1.
    assign addr_free   = tos_ptr[AW-1:0];
    assign addr_top    = addr_free - AW'(1);
    assign addr_second = addr_free - AW'(2);

    assign full      = (tos_ptr == PTR_FULL);
    assign empty     = (tos_ptr == '0);
    assign cmd_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign accept    = cmd_valid & cmd_ready;
    assign flt       = fault_code(cmd_op, full, empty, tos_ptr < PTR_W'(2));
    assign flt_now   = accept && (flt != FLT_NONE);
    assign op_cur    = cmd_ready ? cmd_op : op_q;

    stack_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        ram_we    = 1'b0;
        ram_addr  = addr_top;
        ram_wdata = temp_a;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (flt != FLT_NONE) begin
                        state_d = ST_RESP;
                    end else begin
                        case (cmd_op)
                            STK_PUSH: begin
                                ram_we    = 1'b1;
                                ram_addr  = addr_free;
                                ram_wdata = cmd_data;
                                state_d   = ST_RESP;
                            end
                            STK_POP, STK_POP2, STK_DUP, STK_SWAP, STK_PEEK:
                                state_d = ST_RD_A;
                            default:
                                state_d = ST_RESP;
                        endcase
                    end
                end
            end
            ST_RD_A: begin
                case (op_q)
                    STK_POP2, STK_SWAP: begin
                        ram_addr = addr_second;
                        state_d  = ST_RD_B;
                    end
                    STK_DUP: state_d = ST_WR_A;
                    default: state_d = ST_RESP;
                endcase
            end
            ST_RD_B: begin
                // SWAP overlaps the first write-back with capturing the second operand.
                if (op_q == STK_SWAP) begin
                    ram_we   = 1'b1;
                    ram_addr = addr_second;
                    state_d  = ST_WR_B;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WR_A: begin
                ram_we   = 1'b1;
                ram_addr = addr_free;
                state_d  = ST_RESP;
            end
            ST_WR_B: begin
                ram_we    = 1'b1;
                ram_wdata = temp_b;
                state_d   = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= STK_NOP;
            temp_a    <= '0;
            temp_b    <= '0;
            tos_ptr   <= '0;
            rsp_a     <= '0;
            rsp_b     <= '0;
            rsp_fault <= 1'b0;
            err_ovf   <= 1'b0;
            err_unf   <= 1'b0;
        end else begin
            if (accept) begin
                op_q <= cmd_op;
                if (flt == FLT_OVF)
                    err_ovf <= 1'b1;
                if (flt == FLT_UNF)
                    err_unf <= 1'b1;
                if (cmd_op == STK_CLEAR) begin
                    err_ovf <= 1'b0;
                    err_unf <= 1'b0;
                end
            end
            if (state_q == ST_RD_A)
                temp_a <= ram_rdata;
            if (state_q == ST_RD_B)
                temp_b <= ram_rdata;
            // Pointer and response registers change on the edge into RESP only.
            if (enter_resp) begin
                rsp_fault <= flt_now;
                if (!flt_now) begin
                    case (op_cur)
                        STK_PUSH:  tos_ptr <= tos_ptr + PTR_W'(1);
                        STK_CLEAR: tos_ptr <= '0;
                        STK_PEEK:  rsp_a   <= ram_rdata;
                        STK_POP: begin
                            rsp_a   <= ram_rdata;
                            tos_ptr <= tos_ptr - PTR_W'(1);
                        end
                        STK_POP2: begin
                            rsp_a   <= temp_a;
                            rsp_b   <= ram_rdata;
                            tos_ptr <= tos_ptr - PTR_W'(2);
                        end
                        STK_DUP: begin
                            rsp_a   <= temp_a;
                            tos_ptr <= tos_ptr + PTR_W'(1);
                        end
                        STK_SWAP: begin
                            rsp_a <= temp_a;
                            rsp_b <= temp_b;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_data_stack_unit.sv
// Directed bench for data_stack_unit (DATA_W=16, DEPTH=4) with a stack model feeding a
// response scoreboard; each response is checked for latency, operands, pointer and flags.
module tb_data_stack_unit;
    import stack_pkg::*;

    localparam int DW  = 16;
    localparam int DEP = 4;
    localparam int PW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [2:0]    cmd_op = STK_NOP;
    logic [DW-1:0] cmd_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_a, rsp_b;
    logic          rsp_fault;
    logic [PW-1:0] tos_ptr;
    logic          full, empty, err_ovf, err_unf;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int            lat;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          flt;
        logic [PW-1:0] ptr;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] mem_m[DEP];
    int            mptr = 0;
    logic          movf = 1'b0, munf = 1'b0;
    logic [DW-1:0] ma = '0, mb = '0;

    data_stack_unit #(.DATA_W(DW), .DEPTH(DEP), .PTR_W(PW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .rsp_valid (rsp_valid),
        .rsp_a     (rsp_a),
        .rsp_b     (rsp_b),
        .rsp_fault (rsp_fault),
        .tos_ptr   (tos_ptr),
        .full      (full),
        .empty     (empty),
        .err_ovf   (err_ovf),
        .err_unf   (err_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference stack: computes the expected response and queues it.
    task automatic model(input logic [2:0] op, input logic [DW-1:0] d);
        exp_t e;
        logic ovf_f, unf_f;
        ovf_f = (op == STK_PUSH || op == STK_DUP) && (mptr == DEP);
        unf_f = ((op == STK_DUP || op == STK_POP || op == STK_PEEK) && (mptr == 0)) ||
                ((op == STK_POP2 || op == STK_SWAP) && (mptr < 2));
        e.flt = ovf_f | unf_f;
        e.lat = 1;
        if (ovf_f) movf = 1'b1;
        if (unf_f) munf = 1'b1;
        if (!e.flt) begin
            case (op)
                STK_CLEAR: begin mptr = 0; movf = 1'b0; munf = 1'b0; end
                STK_PUSH:  begin mem_m[mptr] = d; mptr++; end
                STK_PEEK:  begin e.lat = 2; ma = mem_m[mptr-1]; end
                STK_POP:   begin e.lat = 2; ma = mem_m[mptr-1]; mptr--; end
                STK_POP2: begin
                    e.lat = 3; ma = mem_m[mptr-1]; mb = mem_m[mptr-2]; mptr -= 2;
                end
                STK_DUP: begin
                    e.lat = 3; ma = mem_m[mptr-1]; mem_m[mptr] = ma; mptr++;
                end
                STK_SWAP: begin
                    e.lat = 4; ma = mem_m[mptr-1]; mb = mem_m[mptr-2];
                    mem_m[mptr-1] = mb; mem_m[mptr-2] = ma;
                end
                default: ;
            endcase
        end
        e.a = ma; e.b = mb; e.ptr = PW'(mptr); e.ovf = movf; e.unf = munf;
        sb.push_back(e);
    endtask

    task automatic run(input logic [2:0] op, input logic [DW-1:0] d, input string tag);
        exp_t e;
        int   lat;
        bit   seen;
        model(op, d);
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk);
        #1 cmd_valid = 1'b0; cmd_data = DW'($urandom);
        seen = 0; lat = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) chk({tag, ".ready_low"}, 32'(cmd_ready), 32'd0);
            if (rsp_valid) seen = 1;
        end
        e = sb.pop_front();
        tests++;
        assert (seen)
        else begin
            fails++;
            $error("FAIL %s.timeout observed=no_rsp expected=rsp", tag);
        end
        if (seen) begin
            chk({tag, ".lat"},   32'(lat),       32'(e.lat));
            chk({tag, ".a"},     32'(rsp_a),     32'(e.a));
            chk({tag, ".b"},     32'(rsp_b),     32'(e.b));
            chk({tag, ".fault"}, 32'(rsp_fault), 32'(e.flt));
            chk({tag, ".ptr"},   32'(tos_ptr),   32'(e.ptr));
            chk({tag, ".full"},  32'(full),      32'(e.ptr == PW'(DEP)));
            chk({tag, ".empty"}, 32'(empty),     32'(e.ptr == '0));
            chk({tag, ".ovf"},   32'(err_ovf),   32'(e.ovf));
            chk({tag, ".unf"},   32'(err_unf),   32'(e.unf));
            @(negedge clk);
            chk({tag, ".rsp_one_cycle"}, 32'(rsp_valid), 32'd0);
            chk({tag, ".ready_back"},    32'(cmd_ready), 32'd1);
        end
    endtask

    initial begin
        bit seen;
        repeat (2) @(negedge clk);
        chk("rst.ptr",   32'(tos_ptr),   32'd0);
        chk("rst.empty", 32'(empty),     32'd1);
        chk("rst.full",  32'(full),      32'd0);
        chk("rst.ready", 32'(cmd_ready), 32'd1);
        chk("rst.rsp_v", 32'(rsp_valid), 32'd0);
        chk("rst.a",     32'(rsp_a),     32'd0);
        chk("rst.b",     32'(rsp_b),     32'd0);
        chk("rst.fault", 32'(rsp_fault), 32'd0);
        chk("rst.ovf",   32'(err_ovf),   32'd0);
        chk("rst.unf",   32'(err_unf),   32'd0);
        rst = 1'b0;

        run(STK_PUSH, 16'h0011, "push11");
        run(STK_PUSH, 16'h0022, "push22");
        run(STK_PUSH, 16'h0033, "push33");
        run(STK_NOP,  16'hDEAD, "nop");
        run(STK_POP2, 16'h0000, "pop2");
        run(STK_PEEK, 16'h0000, "peek");
        run(STK_PUSH, 16'hAAAA, "pushAA");
        run(STK_SWAP, 16'h0000, "swap");
        run(STK_POP,  16'h0000, "pop_a");
        run(STK_POP,  16'h0000, "pop_b");

        run(STK_PUSH, 16'h0101, "fill0");
        run(STK_PUSH, 16'h0202, "fill1");
        run(STK_PUSH, 16'h0303, "fill2");
        run(STK_PUSH, 16'h0404, "fill3");
        run(STK_PUSH, 16'hBEEF, "push_ovf");
        run(STK_DUP,  16'h0000, "dup_ovf");
        run(STK_PEEK, 16'h0000, "peek_full");
        run(STK_CLEAR, 16'h0000, "clear");

        run(STK_POP,  16'h0000, "pop_unf");
        run(STK_PEEK, 16'h0000, "peek_unf");
        run(STK_POP2, 16'h0000, "pop2_unf");
        run(STK_PUSH, 16'h0005, "push5");
        run(STK_SWAP, 16'h0000, "swap_unf");
        run(STK_POP,  16'h0000, "pop5");

        run(STK_PUSH, 16'h1234, "push1234");
        run(STK_DUP,  16'h0000, "dup");
        run(STK_POP2, 16'h0000, "pop2_dup");

        // Reset lands two cycles into a SWAP: the command must vanish without a response.
        run(STK_PUSH, 16'h0001, "pre_swap1");
        run(STK_PUSH, 16'h0002, "pre_swap2");
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = STK_SWAP; cmd_data = '0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        seen = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        mptr = 0; movf = 1'b0; munf = 1'b0; ma = '0; mb = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        chk("abort.no_rsp", 32'(seen),      32'd0);
        chk("abort.ptr",    32'(tos_ptr),   32'd0);
        chk("abort.ready",  32'(cmd_ready), 32'd1);
        chk("abort.a",      32'(rsp_a),     32'd0);

        run(STK_PUSH, 16'h0077, "post_push");
        run(STK_PEEK, 16'h0000, "post_peek");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
